rotate_right_seq: RTL

Sequential inverse rotator: accepts a WIDTH-bit word rotated left by `in_amt` positions and recovers the original word by rotating it right by `in_amt`, one position per clock. It is the decode side of the combinational left-rotate barrel shifter in the datapath. Ready/valid handshakes on both sides let it sit between a producer and a consumer without added glue. Iterative operation trades latency for area: one register, one 1-bit rotate path, one down-counter.

---
 rtl/rotate_right_seq.sv | 80 ++++++++
 1 files changed

// File: rtl/rotate_right_seq.sv
// Iterative right rotator: undoes a left rotate of in_amt positions, one bit
// position per clock, with ready/valid handshakes on both sides.
module rotate_right_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, out_valid_q, busy_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_amt;
          state_d = (in_amt != '0) ? ROTATE : HOLD;
        end
      end
      ROTATE: begin
        data_d = {data_q[0], data_q[WIDTH-1:1]};
        cnt_d  = cnt_q - AMT_W'(1);
        // Last step when the counter reads 1, so cnt_q lands on 0 in HOLD.
        if (cnt_q == AMT_W'(1)) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state, so every output
  // comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;

endmodule
